key_debounce: RTL and testbench

Single-key debouncer with press-edge detection, placed between a raw mechanical push-button input and the synchronous control logic. It synchronizes the asynchronous key level into the clock domain and filters contact bounce. It emits exactly one single-cycle pulse per debounced press; release produces no pulse.

---
 rtl/key_debounce_if.sv | 8 +
 rtl/key_debounce.sv | 49 ++++
 tb/tb_key_debounce.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - key level in, press pulse out
interface key_debounce_if;
  logic key;
  logic key_pulse;

  modport master (output key, input key_pulse);
  modport slave  (input key, output key_pulse);
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchronizer, bounce filter, press-edge pulse
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic           clk,
  input  logic           rst,
  key_debounce_if.slave  kif
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic          RELEASED = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic          PRESSED  = ~RELEASED;
  localparam logic [CW-1:0] LAST     = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          pulse_q;

  // Any sample matching the accepted level restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= RELEASED;
      sync2   <= RELEASED;
      stable  <= RELEASED;
      cnt     <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1   <= kif.key;
      sync2   <= sync1;
      pulse_q <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable  <= sync2;
        cnt     <= '0;
        pulse_q <= (sync2 == PRESSED);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign kif.key_pulse = pulse_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed and random checks of key_debounce against a window model
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_debounce_if if0 ();
  key_debounce_if if1 ();

  key_debounce #(.DEBOUNCE_CYCLES(4), .KEY_ACTIVE_LOW(1)) dut0 (
    .clk (clk),
    .rst (rst),
    .kif (if0.slave)
  );

  key_debounce #(.DEBOUNCE_CYCLES(1), .KEY_ACTIVE_LOW(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .kif (if1.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Model: a level is accepted once the last N synchronized samples all
  // differ from the current debounced level.
  int          dc [2];
  logic        rel [2];
  logic [15:0] hist [2];
  logic        st [2];
  logic        p1 [2];
  logic        p2 [2];
  logic        mp [2];

  logic prev0 = 1'b0;
  logic prev1 = 1'b0;
  int   sidx, pidx, pulses0;

  task automatic model_edge(input int i, input logic r, input logic k);
    logic [15:0] mask;
    mask = 16'((1 << dc[i]) - 1);
    if (r) begin
      p1[i] = rel[i]; p2[i] = rel[i]; st[i] = rel[i];
      hist[i] = {16{rel[i]}};
      mp[i] = 1'b0;
    end else begin
      hist[i] = {hist[i][14:0], p2[i]};
      p2[i] = p1[i];
      p1[i] = k;
      mp[i] = 1'b0;
      if ((hist[i] & mask) == (st[i] ? 16'h0000 : mask)) begin
        st[i] = ~st[i];
        mp[i] = (st[i] != rel[i]);
      end
    end
  endtask

  task automatic step(input logic r, input logic k0, input logic k1);
    rst = r;
    if0.key = k0;
    if1.key = k1;
    @(posedge clk);
    model_edge(0, r, k0);
    model_edge(1, r, k1);
    #1;
    checks++;
    assert (if0.key_pulse === mp[0]) else begin
      failures++;
      $error("FAIL pulse0 observed=%b expected=%b t=%0t", if0.key_pulse, mp[0], $time);
    end
    checks++;
    assert (if1.key_pulse === mp[1]) else begin
      failures++;
      $error("FAIL pulse1 observed=%b expected=%b t=%0t", if1.key_pulse, mp[1], $time);
    end
    checks++;
    assert ((prev0 & if0.key_pulse) === 1'b0 && (prev1 & if1.key_pulse) === 1'b0) else begin
      failures++;
      $error("FAIL back_to_back observed=%b%b expected=0 t=%0t", prev0, if0.key_pulse, $time);
    end
    prev0 = if0.key_pulse;
    prev1 = if1.key_pulse;
    if (if0.key_pulse === 1'b1) begin
      pulses0++;
      pidx = sidx;
    end
    sidx++;
  endtask

  task automatic hold(input logic r, input logic k0, input int n);
    for (int j = 0; j < n; j++) step(r, k0, 1'($urandom_range(0, 1)));
  endtask

  task automatic seg_start();
    sidx = 0;
    pidx = -1;
    pulses0 = 0;
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic lv0, lv1;
    int   run;
    dc[0] = 4; rel[0] = 1'b1;
    dc[1] = 1; rel[1] = 1'b0;

    // Reset with key released
    hold(1'b1, 1'b1, 3);
    check_int("rst_stable0", int'(dut0.stable), 1);
    check_int("rst_cnt0", int'(dut0.cnt), 0);
    check_int("rst_stable1", int'(dut1.stable), 0);
    check_int("rst_pulse0", int'(if0.key_pulse), 0);
    hold(1'b0, 1'b1, 3);

    // Clean press
    seg_start();
    hold(1'b0, 1'b0, 8);
    check_int("clean_count", pulses0, 1);
    check_int("clean_index", pidx, 5);
    seg_start();
    hold(1'b0, 1'b1, 8);
    check_int("release_count", pulses0, 0);

    // Bounce rejection
    seg_start();
    hold(1'b0, 1'b0, 2);
    hold(1'b0, 1'b1, 1);
    hold(1'b0, 1'b0, 2);
    hold(1'b0, 1'b1, 8);
    check_int("bounce_count", pulses0, 0);

    // Bounce then hold
    seg_start();
    hold(1'b0, 1'b0, 1);
    hold(1'b0, 1'b1, 1);
    hold(1'b0, 1'b0, 1);
    hold(1'b0, 1'b1, 1);
    hold(1'b0, 1'b0, 6);
    hold(1'b0, 1'b1, 8);
    check_int("bounce_hold_count", pulses0, 1);
    check_int("bounce_hold_index", pidx, 4 + 5);

    // Release and repress
    seg_start();
    hold(1'b0, 1'b0, 6);
    hold(1'b0, 1'b1, 6);
    hold(1'b0, 1'b0, 6);
    hold(1'b0, 1'b1, 8);
    check_int("repress_count", pulses0, 2);

    // Reset mid-count with key held pressed
    seg_start();
    hold(1'b0, 1'b0, 3);
    hold(1'b1, 1'b0, 2);
    check_int("rst_mid_none", pulses0, 0);
    seg_start();
    hold(1'b0, 1'b0, 10);
    check_int("rst_mid_count", pulses0, 1);
    check_int("rst_mid_index", pidx, 5);
    hold(1'b0, 1'b1, 8);

    // Random runs of varying length with occasional reset
    for (int n = 0; n < 600; n++) begin
      lv0 = 1'($urandom_range(0, 1));
      lv1 = 1'($urandom_range(0, 1));
      run = int'($urandom_range(1, 7));
      for (int j = 0; j < run; j++) begin
        if ($urandom_range(0, 99) == 0) step(1'b1, lv0, lv1);
        else step(1'b0, lv0, ($urandom_range(0, 3) == 0) ? ~lv1 : lv1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
